// File: rtl/onchip_mem_arb_pkg.sv
// Shared definitions for the on-chip RAM round-robin arbiter.
//   - default bus widths
//   - master identifiers
//   - read-return tag carried alongside each issued RAM read
package onchip_mem_arb_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 15;
  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned BE_W_DEFAULT   = 4;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/onchip_mem_rr_arbiter_if.sv
// One Avalon-MM master channel into the RAM arbiter.
//   master modport: drives address/byteenable/read/write/writedata,
//                   receives waitrequest/readdata/readdatavalid
//   slave modport : the arbiter side of the same channel
interface onchip_mem_rr_arbiter_if #(
  parameter int unsigned ADDR_W = onchip_mem_arb_pkg::ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = onchip_mem_arb_pkg::DATA_W_DEFAULT,
  parameter int unsigned BE_W   = onchip_mem_arb_pkg::BE_W_DEFAULT
);

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/onchip_mem_rd_tag_pipe.sv
// Shift register carrying one {valid, owner} tag per RAM cycle, aligned with the RAM read
// latency so the tag at the tail matches the data on the RAM output.
//   clk, reset : clock, asynchronous active-high clear
//   tag_i      : tag for the access issued this cycle
//   tag_o      : tag for the data emerging from the RAM this cycle
module onchip_mem_rd_tag_pipe
  import onchip_mem_arb_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t [Depth-1:0] pipe_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < Depth; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[Depth-1];

endmodule

// File: rtl/onchip_mem_rr_arbiter.sv
// Shares one single-port on-chip RAM between two Avalon-MM masters (m0 = CPU data port,
// m1 = matrix engine). One RAM access per cycle, round-robin grant with a bounded hold so
// neither master can starve the other for more than HOLD_MAX consecutive cycles.
//   clk, reset        : clock, asynchronous active-high reset
//   m0_if, m1_if      : Avalon-MM slave channels facing the two masters
//   mem_*_o           : RAM address/byteenable/chipselect/write/writedata/clken
//   mem_readdata_i    : RAM read data, RD_LAT cycles after the read was issued
module onchip_mem_rr_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned BE_W     = BE_W_DEFAULT,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  onchip_mem_rr_arbiter_if.slave  m0_if,
  onchip_mem_rr_arbiter_if.slave  m1_if,
  output logic [ADDR_W-1:0]       mem_address_o,
  output logic [BE_W-1:0]         mem_byteenable_o,
  output logic                    mem_chipselect_o,
  output logic                    mem_write_o,
  output logic [DATA_W-1:0]       mem_writedata_o,
  output logic                    mem_clken_o,
  input  logic [DATA_W-1:0]       mem_readdata_i
);

  localparam logic [3:0] HoldMax = 4'(HOLD_MAX);

  logic       req0, req1, gnt0, gnt1, gnt_any, win;
  logic       ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;

  logic [ADDR_W-1:0] sel_addr, last_addr_q;
  logic [BE_W-1:0]   sel_be, last_be_q;
  logic [DATA_W-1:0] sel_wdata, last_wdata_q;
  logic              sel_read, sel_write;

  rd_tag_t           tag_in, tag_out;
  logic              rdv0, rdv1;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  assign req0 = m0_if.read | m0_if.write;
  assign req1 = m1_if.read | m1_if.write;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        // Pointer owner keeps the RAM until it has used up its hold allowance.
        if ((ptr_q == M0) == (hold_q < HoldMax)) gnt0 = 1'b1;
        else                                     gnt1 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign gnt_any = gnt0 | gnt1;
  assign win     = gnt1 ? M1 : M0;

  always_comb begin
    ptr_d  = ptr_q;
    hold_d = 4'd0;
    if (gnt_any) begin
      ptr_d = win;
      if (win == ptr_q) hold_d = (hold_q == 4'hF) ? hold_q : hold_q + 4'd1;
      else              hold_d = 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q  <= M0;
      hold_q <= 4'd0;
    end else begin
      ptr_q  <= ptr_d;
      hold_q <= hold_d;
    end
  end

  assign sel_addr  = win ? m1_if.address    : m0_if.address;
  assign sel_be    = win ? m1_if.byteenable : m0_if.byteenable;
  assign sel_wdata = win ? m1_if.writedata  : m0_if.writedata;
  assign sel_read  = win ? m1_if.read       : m0_if.read;
  assign sel_write = win ? m1_if.write      : m0_if.write;

  // Keep the RAM bus steady on idle cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_addr_q  <= '0;
      last_be_q    <= '0;
      last_wdata_q <= '0;
    end else if (gnt_any) begin
      last_addr_q  <= sel_addr;
      last_be_q    <= sel_be;
      last_wdata_q <= sel_wdata;
    end
  end

  assign mem_address_o    = gnt_any ? sel_addr  : last_addr_q;
  assign mem_byteenable_o = gnt_any ? sel_be    : last_be_q;
  assign mem_writedata_o  = gnt_any ? sel_wdata : last_wdata_q;
  assign mem_chipselect_o = gnt_any;
  assign mem_write_o      = gnt_any & sel_write;
  assign mem_clken_o      = ~reset;

  assign m0_if.waitrequest = reset | (req0 & ~gnt0);
  assign m1_if.waitrequest = reset | (req1 & ~gnt1);

  // Read+write together is a write, so only a pure read earns a return tag.
  assign tag_in.valid = gnt_any & sel_read & ~sel_write;
  assign tag_in.owner = win;

  onchip_mem_rd_tag_pipe #(
    .Depth (RD_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign rdv0 = tag_out.valid & (tag_out.owner == M0);
  assign rdv1 = tag_out.valid & (tag_out.owner == M1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rdv0) rdata0_q <= mem_readdata_i;
      if (rdv1) rdata1_q <= mem_readdata_i;
    end
  end

  assign m0_if.readdatavalid = rdv0;
  assign m1_if.readdatavalid = rdv1;
  assign m0_if.readdata      = rdv0 ? mem_readdata_i : rdata0_q;
  assign m1_if.readdata      = rdv1 ? mem_readdata_i : rdata1_q;

endmodule
